bellek_yanitlayici: RTL

//  Memory responder for the processor's single-port bus (bellek_adres / bellek_oku_veri /

---
 rtl/bellek_yanitlayici.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/bellek_yanitlayici.sv
// ============================================================================
//  Module      : bellek_yanitlayici
//  Description : Single-port word memory responder for the processor bus, with
//                a program-load port that holds the processor in reset until
//                the image is loaded.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bellek_yanitlayici #(
    parameter int unsigned          ADDR_W      = 32,
    parameter int unsigned          DATA_W      = 32,
    parameter int unsigned          CNT_W       = 16,
    parameter int unsigned          DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0]    BASE_ADDR   = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   bellek_adres,
    output logic [DATA_W-1:0]   bellek_oku_veri,
    input  logic [DATA_W-1:0]   bellek_yaz_veri,
    input  logic                bellek_yaz,
    input  logic                yukle_gecerli,
    input  logic [DATA_W-1:0]   yukle_veri,
    input  logic                yukle_son,
    output logic                yukle_hazir,
    output logic                islemci_rst,
    output logic                hata,
    output logic [CNT_W-1:0]    yaz_sayaci
);

    localparam int unsigned         c_IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0]   c_SPAN    = ADDR_W'(4 * DEPTH_WORDS);
    localparam logic [c_IDX_W-1:0]  c_SON_IDX = c_IDX_W'(DEPTH_WORDS - 1);

    localparam logic [1:0] c_YUKLE = 2'd0;
    localparam logic [1:0] c_BIRAK = 2'd1;
    localparam logic [1:0] c_CALIS = 2'd2;

    logic [DATA_W-1:0]  mem_q [DEPTH_WORDS];

    logic [1:0]         state_q, state_d;
    logic [c_IDX_W-1:0] ptr_q,   ptr_d;
    logic               hata_q,  hata_d;
    logic [CNT_W-1:0]   sayac_q, sayac_d;

    logic [ADDR_W-1:0]  w_off;
    logic               w_in_range;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_yukle_hs;
    logic               w_yukle_bitti;
    logic               w_yukle_tasma;
    logic               w_calis;
    logic               w_yaz_ok;
    logic               w_erisim_hata;
    logic               w_mem_we;
    logic [c_IDX_W-1:0] w_mem_idx;
    logic [DATA_W-1:0]  w_mem_veri;

    // ------------------------------------------------------------------------
    // Address decode, shared by reads, processor writes and error detection
    // ------------------------------------------------------------------------
    assign w_off      = bellek_adres - BASE_ADDR;
    assign w_in_range = (w_off < c_SPAN) && (w_off[1:0] == 2'b00);
    assign w_idx      = w_off[c_IDX_W+1:2];

    assign bellek_oku_veri = w_in_range ? mem_q[w_idx] : '0;

    // ------------------------------------------------------------------------
    // Event qualifiers
    // ------------------------------------------------------------------------
    assign w_yukle_hs    = yukle_gecerli & yukle_hazir;
    assign w_yukle_bitti = w_yukle_hs & (yukle_son | (ptr_q == c_SON_IDX));
    assign w_yukle_tasma = w_yukle_hs & (ptr_q == c_SON_IDX) & ~yukle_son;

    // Processor accesses only matter once it has been released from reset.
    assign w_calis       = (state_q == c_CALIS) & ~rst;
    assign w_yaz_ok      = w_calis & bellek_yaz & w_in_range;
    assign w_erisim_hata = w_calis & ~w_in_range;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_YUKLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_YUKLE: begin
                if (w_yukle_bitti) begin
                    state_d = c_BIRAK;
                end
            end
            c_BIRAK: state_d = c_CALIS;
            c_CALIS: state_d = c_CALIS;
            default: state_d = c_YUKLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs (reset overrides the state so the processor is held at once)
    // ------------------------------------------------------------------------
    always_comb begin
        yukle_hazir = 1'b0;
        islemci_rst = 1'b1;
        case (state_q)
            c_YUKLE: yukle_hazir = ~rst;
            c_BIRAK: yukle_hazir = 1'b0;
            c_CALIS: islemci_rst = rst;
            default: begin
                yukle_hazir = 1'b0;
                islemci_rst = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Load pointer, sticky error and write counter
    // ------------------------------------------------------------------------
    always_comb begin
        ptr_d   = ptr_q;
        hata_d  = hata_q;
        sayac_d = sayac_q;
        if (w_yukle_hs) begin
            ptr_d = ptr_q + c_IDX_W'(1);
        end
        if (w_yukle_tasma || w_erisim_hata) begin
            hata_d = 1'b1;
        end
        if (w_yaz_ok && (sayac_q != '1)) begin
            sayac_d = sayac_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            hata_q  <= 1'b0;
            sayac_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            hata_q  <= hata_d;
            sayac_q <= sayac_d;
        end
    end

    assign hata       = hata_q;
    assign yaz_sayaci = sayac_q;

    // ------------------------------------------------------------------------
    // Word array: one write port, shared by loader and processor (their
    // enables are mutually exclusive by state). Contents survive reset.
    // ------------------------------------------------------------------------
    assign w_mem_we   = w_yukle_hs | w_yaz_ok;
    assign w_mem_idx  = w_yukle_hs ? ptr_q      : w_idx;
    assign w_mem_veri = w_yukle_hs ? yukle_veri : bellek_yaz_veri;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[w_mem_idx] <= w_mem_veri;
        end
    end

endmodule

`default_nettype wire
